tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 Parameter TIMEOUT, default 1023, max cycles to wait for tx_busy to rise after tx_send.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester level request; req[i]=1 means data byte i is valid.
REQ-006 data  input  8*NREQ  requester bytes; requester i owns data[8*i+7:8*i].
REQ-007 ack  output  NREQ  one-cycle pulse to requester i when its byte has been captured.
REQ-008 tx_send  output  1  send strobe to the UART transmitter.
REQ-009 tx_din  output  8  byte presented to the transmitter, registered.
REQ-010 tx_busy  input  1  transmitter busy flag.
REQ-011 grant_id  output  3  index of the requester being serviced, or last serviced.
REQ-012 active  output  1  high whenever state is not IDLE.
REQ-013 timeout_err  output  1  sticky error flag, cleared only by rst.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO.
REQ-015 IDLE: if any req bit is high and tx_busy is low, the block SHALL choose a requester by round-robin and go to SEND on the next edge; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin: search starts at index (last_grant+1) mod NREQ and wraps upward; the first index with req high wins; after reset, last_grant = NREQ-1, so index 0 has top priority.
REQ-017 On the IDLE->SEND edge the block SHALL register tx_din <= data[winner], grant_id <= winner, last_grant <= winner, and pulse ack[winner] for exactly that one cycle.
REQ-018 Latency: req sampled high at edge N gives ack and tx_send both high in cycle N+1.
REQ-019 SEND and WAIT_BUSY_HI: tx_send SHALL be held high; when tx_busy is sampled high, go to WAIT_BUSY_LO and drop tx_send.
REQ-020 WAIT_BUSY_LO: tx_send SHALL be low; when tx_busy is sampled low, return to IDLE.
REQ-021 From the byte-done edge, the next grant SHALL take at least 1 idle cycle.
REQ-022 Changes on req or data after capture SHALL NOT affect tx_din until the next grant.
REQ-023 A requester that drops req before it is granted SHALL be skipped without an ack.
REQ-024 A 10-bit watchdog SHALL count cycles spent in SEND/WAIT_BUSY_HI.
REQ-025 If the watchdog reaches TIMEOUT with tx_busy still low, the block SHALL set timeout_err, drop tx_send, and return to IDLE; last_grant is still updated, so that requester loses its turn.
REQ-026 The watchdog SHALL clear on every entry to SEND.
REQ-027 WAIT_BUSY_LO has no timeout.
REQ-028 ack SHALL be one-hot or zero in every cycle.
REQ-029 tx_send SHALL be low in IDLE and WAIT_BUSY_LO.
REQ-030 tx_busy high in IDLE SHALL block any grant.

Reset
REQ-031 rst high SHALL immediately force state IDLE, tx_send=0, tx_din=0, ack=0, grant_id=0, active=0, timeout_err=0, last_grant=NREQ-1, watchdog=0.
REQ-032 rst high mid-transfer SHALL abandon the byte with no ack and no retry.
REQ-033 After rst is released, the first grant SHALL need a full IDLE evaluation cycle.

Verification
REQ-034 Single request: req=0001, data[7:0]=8'h41, busy model rises 2 cycles after send and lasts 20 cycles -> ack[0] pulses once, tx_din=8'h41, tx_send high for 3 cycles, active low 1 cycle after busy falls.
REQ-035 All requesting: req=1111 held, bytes 0x10/0x11/0x12/0x13 -> transmitted order 0x10, 0x11, 0x12, 0x13, 0x10; grant_id sequence 0,1,2,3,0.
REQ-036 Wrap and skip: last_grant=2, req=0101 -> next grant is index 0 (3 is skipped, then wrap), followed by index 2.
REQ-037 Timeout: tx_busy tied low, req=0010 -> tx_send high for exactly TIMEOUT cycles, then timeout_err=1 and state IDLE; with req still high, the block re-grants index 1 on a later cycle.
REQ-038 Reset mid-byte: rst asserted during WAIT_BUSY_LO -> all outputs equal their reset values within the same cycle, and after release index 0 wins over index 3 with req=1001.
REQ-039 Data stability: data[0] changed from 0x55 to 0xAA one cycle after ack[0] -> tx_din stays 0x55 until the next grant.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter that feeds one byte at a time from NREQ
// requesters into a UART transmitter. It hands the byte over with a send
// strobe, waits for the transmitter to report busy, then waits for busy to
// clear. A watchdog abandons a byte whose busy handshake never starts.
module tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   data,
    output logic [NREQ-1:0]     ack,
    output logic                tx_send,
    output logic [7:0]          tx_din,
    input  logic                tx_busy,
    output logic [2:0]          grant_id,
    output logic                active,
    output logic                timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Watchdog value seen during the last allowed cycle of send strobing.
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);
    localparam logic [2:0] LAST_IDX  = 3'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      last_grant_q, last_grant_d;
    logic [9:0]      wdog_q, wdog_d;
    logic [7:0]      tx_din_q, tx_din_d;
    logic [2:0]      grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;

    // Requests and bytes padded to 8 lanes so a 3-bit index always fits.
    logic [7:0]      req_pad;
    logic [7:0]      byte_pad [8];
    logic [NREQ-1:0] win_onehot;
    logic            rr_found;
    logic [2:0]      rr_winner;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < NREQ) begin : g_used
                assign req_pad[gi]  = req[gi];
                assign byte_pad[gi] = data[8*gi +: 8];
            end else begin : g_unused
                assign req_pad[gi]  = 1'b0;
                assign byte_pad[gi] = 8'h00;
            end
        end
        for (gi = 0; gi < NREQ; gi++) begin : g_win
            assign win_onehot[gi] = (rr_winner == 3'(gi));
        end
    endgenerate

    // Round-robin search: start just after the last grant, wrap upward.
    always_comb begin
        logic [2:0] cand;
        rr_found  = 1'b0;
        rr_winner = last_grant_q;
        cand      = (last_grant_q == LAST_IDX) ? 3'd0 : last_grant_q + 3'd1;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && req_pad[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
            cand = (cand == LAST_IDX) ? 3'd0 : cand + 3'd1;
        end
    end

    // Next-state logic for the grant / send / busy handshake sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        tx_din_d     = tx_din_q;
        grant_d      = grant_q;
        ack_d        = '0;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found && !tx_busy) begin
                    state_d      = ST_SEND;
                    tx_din_d     = byte_pad[rr_winner];
                    grant_d      = rr_winner;
                    last_grant_d = rr_winner;
                    ack_d        = win_onehot;
                    wdog_d       = '0;
                end
            end
            ST_SEND, ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (wdog_q == WDOG_LAST) begin
                    // Transmitter never answered: drop the byte; the
                    // requester has already lost its turn via last_grant.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d  = wdog_q + 10'd1;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_IDX;
            wdog_q       <= '0;
            tx_din_q     <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            tx_din_q     <= tx_din_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign tx_send     = (state_q == ST_SEND) || (state_q == ST_WAIT_HI);
    assign active      = (state_q != ST_IDLE);
    assign tx_din      = tx_din_q;
    assign grant_id    = grant_q;
    assign ack         = ack_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter. Stimulus computes the
// expected grant order of each request burst from the round-robin rule and
// queues it; a monitor pops one entry per ack and checks it. A small busy
// model plays the role of the UART transmitter.
module tb_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 200 * NREQ;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   data = '0;
    logic                tx_busy = 1'b0;
    logic [NREQ-1:0]     ack;
    logic                tx_send;
    logic [7:0]          tx_din;
    logic [2:0]          grant_id;
    logic                active;
    logic                timeout_err;

    tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
        .tx_send(tx_send), .tx_din(tx_din), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [7:0] b; } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad = 0;
    int model_last = NREQ - 1;
    int busy_mode = 0;      // 0: busy model answers tx_send, 1: bench drives tx_busy
    int rise_dly = 1;
    int busy_len = 3;
    int send_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy rises rise_dly cycles after the strobe, lasts busy_len.
    task automatic busy_proc();
        int rc = 0;
        int left = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || busy_mode != 0) begin
                rc = 0;
                left = 0;
                if (rst) tx_busy = 1'b0;
            end else if (left > 0) begin
                left--;
                if (left == 0) tx_busy = 1'b0;
            end else if (tx_send) begin
                if (rc >= rise_dly) begin
                    tx_busy = 1'b1;
                    left = busy_len;
                    rc = 0;
                end else begin
                    rc++;
                end
            end
        end
    endtask

    // Monitor: pops one expected grant per ack and checks invariants each cycle.
    task automatic monitor();
        logic [7:0] cur = 8'h00;
        bit have = 0;
        logic prev_active = 1'b0;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            tick();
            if (rst) begin
                have = 0;
            end else begin
                check("ack_onehot0", 32'($onehot0(ack)), 1);
                if (tx_send) send_cnt++;
                if (prev_busy && !tx_busy && ack == 0) check("active_after_busy_fall", active, 0);
                if (ack != 0) begin
                    check("idle_gap_before_grant", prev_active, 0);
                    check("send_with_ack", tx_send, 1);
                    if (sb_q.size() == 0) begin
                        check("unexpected_ack", ack, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("ack_vec", ack, 1 << e.id);
                        check("grant_id", grant_id, e.id);
                        check("tx_din", tx_din, e.b);
                        $display("grant id=%0d byte=%02h t=%0t", grant_id, tx_din, $time);
                        cur = e.b;
                        have = 1;
                    end
                end else if (have) begin
                    check("tx_din_hold", tx_din, cur);
                end
            end
            prev_active = active;
            prev_busy = tx_busy;
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((active || tx_busy) && c < 500) begin
            tick();
            c++;
        end
        check("idle_reached", active | tx_busy, 0);
    endtask

    // One burst: all masked requesters raise req at once and each drops on its ack.
    task automatic run_burst(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] bytes,
                             input bit cancel_en, input int rise, input int len);
        int order[$];
        int cancel = -1;
        int cyc = 0;
        int got = 0;
        int n;
        wait_idle();
        busy_mode = 0;
        rise_dly = rise;
        busy_len = len;
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (model_last + k) % NREQ;
            if (mask[idx]) order.push_back(idx);
        end
        if (cancel_en && order.size() >= 2) begin
            int p = int'($urandom_range(order.size() - 1, 1));
            cancel = order[p];
            order.delete(p);
        end
        n = order.size();
        foreach (order[j]) begin
            exp_t e;
            e.id = order[j];
            e.b = bytes[8*order[j] +: 8];
            sb_q.push_back(e);
        end
        model_last = order[n-1];
        data = bytes;
        req = mask;
        while (got < n && cyc < BUDGET) begin
            tick();
            cyc++;
            if (ack != 0) begin
                if (got == 0) check("first_grant_latency", cyc, 1);
                got++;
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) begin
                        req[i] = 1'b0;
                        data[8*i +: 8] = ~data[8*i +: 8];
                    end
                end
                if (cancel >= 0) begin
                    req[cancel] = 1'b0;
                    cancel = -1;
                end
            end
        end
        check("burst_ack_count", got, n);
        if (got < n) sb_q.delete();
        req = '0;
    endtask

    initial begin
        int cyc;
        int n;
        exp_t e;
        fork
            monitor();
            busy_proc();
        join_none

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_ack", ack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // All requesting, then requester 0 again: 0,1,2,3,0
        run_burst(4'b1111, 32'h13121110, 0, 1, 3);
        run_burst(4'b0001, 32'h13121110, 0, 1, 3);

        // Set last grant to 2, then 0101 wraps to 0 before 2
        run_burst(4'b0100, 32'h00220000, 0, 0, 2);
        run_burst(4'b0101, 32'h00B200B0, 0, 2, 4);

        // Single request with slow transmitter: strobe lasts 3 cycles
        wait_idle();
        send_cnt = 0;
        run_burst(4'b0001, 32'h00000041, 0, 2, 20);
        wait_idle();
        check("single_send_cycles", send_cnt, 3);

        // Data change after capture must not reach tx_din (0x55 -> 0xAA)
        run_burst(4'b0001, 32'h00000055, 0, 1, 4);
        wait_idle();
        check("data_flipped_by_driver", data[7:0], 8'hAA);

        // tx_busy high in idle blocks any grant
        wait_idle();
        busy_mode = 1;
        #1 tx_busy = 1'b1;
        e.id = 0; e.b = 8'hC3;
        sb_q.push_back(e);
        data[7:0] = 8'hC3;
        req = 4'b0001;
        repeat (5) begin
            tick();
            check("busy_blocks_ack", ack, 0);
            check("busy_blocks_active", active, 0);
        end
        #1 tx_busy = 1'b0;
        cyc = 0;
        while (ack == 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("grant_after_busy_release", cyc, 1);
        req = '0;
        rise_dly = 1;
        busy_len = 3;
        busy_mode = 0;
        model_last = 0;

        // Watchdog: busy tied low, req held -> timeout, then re-grant of index 1
        wait_idle();
        busy_mode = 1;
        e.id = 1; e.b = 8'h5A;
        sb_q.push_back(e);
        sb_q.push_back(e);
        data[15:8] = 8'h5A;
        req = 4'b0010;
        cyc = 0;
        while (!tx_send && cyc < 10) begin
            tick();
            cyc++;
        end
        n = 0;
        while (tx_send && n < TIMEOUT + 10) begin
            n++;
            tick();
        end
        check("timeout_send_cycles", n, TIMEOUT);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_back_idle", active, 0);
        cyc = 0;
        while (ack == 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("regrant_index1", ack, 4'b0010);
        req = '0;
        wait_idle();
        busy_mode = 0;
        model_last = 1;

        // Reset during WAIT_BUSY_LO, then 1001 must grant 0 before 3
        rise_dly = 1;
        busy_len = 30;
        e.id = 3; e.b = 8'h77;
        sb_q.push_back(e);
        data[31:24] = 8'h77;
        req = 4'b1000;
        cyc = 0;
        while (ack == 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        req = '0;
        cyc = 0;
        while (!(tx_busy && !tx_send) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("reached_wait_busy_lo", tx_busy & ~tx_send & active, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_send", tx_send, 0);
        check("midrst_tx_din", tx_din, 0);
        check("midrst_ack", ack, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_active", active, 0);
        check("midrst_timeout_err", timeout_err, 0);
        tick();
        tick();
        rst = 1'b0;
        model_last = NREQ - 1;
        sb_q.delete();
        run_burst(4'b1001, 32'h39000030, 0, 1, 3);

        // Randomised bursts, some with a requester withdrawing before its grant
        repeat (40) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_burst(m, $urandom, 1, int'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
        end
        wait_idle();
        tick();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
